hop_rst_pipe: RTL and testbench



---
 rtl/hop_pkg.sv | 14 +
 rtl/hop_rst_sync.sv | 22 ++
 rtl/hop_rst_pipe.sv | 103 ++++++++++
 tb/tb_hop_rst_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hop_pkg.sv
// Shared constants and helpers for the hop benchmark family.
package hop_pkg;

  localparam int HOP_MODE_LEVEL = 0;
  localparam int HOP_MODE_RISE  = 1;

  // Fill-counter width: clog2(depth), never narrower than one bit.
  function automatic int hop_cntw(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hop_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; srst_out is active-high.
module hop_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock0,
  input  logic arst,
  output logic srst_out
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clock0 or posedge arst) begin
    if (arst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign srst_out = ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/hop_rst_pipe.sv
// Multi-channel flop pipeline: stage 0 in the global rst1 domain, later stages,
// fill counter and edge detector in a synchronised per-channel reset domain.
module hop_rst_pipe
  import hop_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = HOP_MODE_LEVEL
) (
  input  logic           clock0,
  input  logic           rst1,
  input  logic [NCH-1:0] rst_ch,
  input  logic [NCH-1:0] start,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] dvalid
);

  localparam int              CNTW    = hop_cntw(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH - 1);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic            w_arst;
    logic            w_crst;
    logic            r_s0;
    logic            w_last;
    logic [CNTW-1:0] r_cnt;

    assign w_arst = rst1 | rst_ch[gi];

    hop_rst_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clock0  (clock0),
      .arst    (w_arst),
      .srst_out(w_crst)
    );

    // Stage 0 ignores rst_ch so it keeps sampling during a channel reset.
    always_ff @(posedge clock0 or posedge rst1) begin
      if (rst1) begin
        r_s0 <= 1'b0;
      end else begin
        r_s0 <= start[gi];
      end
    end

    if (DEPTH > 1) begin : g_tail
      // r_tail[k-1] holds stage k.
      logic [DEPTH-2:0] r_tail;

      if (DEPTH > 2) begin : g_long
        always_ff @(posedge clock0 or posedge w_crst) begin
          if (w_crst) begin
            r_tail <= '0;
          end else begin
            r_tail <= {r_tail[DEPTH-3:0], r_s0};
          end
        end
      end else begin : g_short
        always_ff @(posedge clock0 or posedge w_crst) begin
          if (w_crst) begin
            r_tail <= '0;
          end else begin
            r_tail <= r_s0;
          end
        end
      end

      assign w_last = r_tail[DEPTH-2];
    end else begin : g_notail
      assign w_last = r_s0;
    end

    always_ff @(posedge clock0 or posedge w_crst) begin
      if (w_crst) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // The crst gate only matters for DEPTH=1, where the counter is stuck at its max.
    assign dvalid[gi] = (r_cnt == CNT_MAX) & ~w_crst;

    if (MODE == HOP_MODE_RISE) begin : g_rise
      logic r_prev;

      always_ff @(posedge clock0 or posedge w_crst) begin
        if (w_crst) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= w_last;
        end
      end

      assign dout[gi] = w_last & ~r_prev;
    end else begin : g_level
      assign dout[gi] = w_last;
    end
  end

endmodule

// File: tb/tb_hop_rst_pipe.sv
// Bench for hop_rst_pipe: three configurations share stimulus; a history-based
// model predicts every output from the sampled inputs and reset timing.
module tb_hop_rst_pipe;

  localparam int NCH  = 4;
  localparam int NCFG = 3;
  localparam int HL   = 8;

  // Clock/reset block
  logic           clock0 = 1'b0;
  logic           rst1   = 1'b1;
  logic [NCH-1:0] rst_ch = '0;
  logic [NCH-1:0] start  = '0;

  always #5 clock0 = ~clock0;

  logic [NCH-1:0] dout_a, dvalid_a, dout_b, dvalid_b, dout_c, dvalid_c;

  hop_rst_pipe #(.NCH(4), .DEPTH(3), .SYNC_STAGES(2), .MODE(0)) u_a (
    .clock0(clock0), .rst1(rst1), .rst_ch(rst_ch), .start(start),
    .dout(dout_a), .dvalid(dvalid_a)
  );

  hop_rst_pipe #(.NCH(4), .DEPTH(2), .SYNC_STAGES(2), .MODE(1)) u_b (
    .clock0(clock0), .rst1(rst1), .rst_ch(rst_ch), .start(start),
    .dout(dout_b), .dvalid(dvalid_b)
  );

  hop_rst_pipe #(.NCH(4), .DEPTH(1), .SYNC_STAGES(3), .MODE(0)) u_c (
    .clock0(clock0), .rst1(rst1), .rst_ch(rst_ch), .start(start),
    .dout(dout_c), .dvalid(dvalid_c)
  );

  function automatic int dep_of(input int c);
    case (c)
      0:       return 3;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int syn_of(input int c);
    return (c == 2) ? 3 : 2;
  endfunction

  function automatic int mode_of(input int c);
    return (c == 1) ? 1 : 0;
  endfunction

  // Reference model: per channel, index 0 = now, index n = n edges ago.
  // hist_sc = clean edges seen since both resets were last low; hist_s0 = stage 0.
  int hist_sc [NCH][HL];
  bit hist_s0 [NCH][HL];

  task automatic model_async();
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst1 || rst_ch[ch]) hist_sc[ch][0] = 0;
      if (rst1) hist_s0[ch][0] = 1'b0;
    end
  endtask

  always @(posedge clock0) begin
    for (int ch = 0; ch < NCH; ch++) begin
      for (int i = HL - 1; i > 0; i--) begin
        hist_sc[ch][i] = hist_sc[ch][i-1];
        hist_s0[ch][i] = hist_s0[ch][i-1];
      end
      hist_sc[ch][0] = (rst1 || rst_ch[ch]) ? 0 :
                       ((hist_sc[ch][1] < 100) ? hist_sc[ch][1] + 1 : 100);
      hist_s0[ch][0] = rst1 ? 1'b0 : start[ch];
    end
  end

  // Edges since the local reset released; negative while it is held.
  function automatic int m_age(input int c, input int ch, input int back);
    return hist_sc[ch][back] - syn_of(c);
  endfunction

  // Last stage = stage 0 from DEPTH-1 edges ago, if the domain has been out
  // of reset long enough for it to have travelled the chain.
  function automatic bit m_last(input int c, input int ch, input int back);
    if (dep_of(c) == 1) return hist_s0[ch][back];
    if (m_age(c, ch, back) >= dep_of(c) - 1) return hist_s0[ch][back + dep_of(c) - 1];
    return 1'b0;
  endfunction

  function automatic logic [NCH-1:0] m_dout(input int c);
    logic [NCH-1:0] v;
    bit prev;
    for (int ch = 0; ch < NCH; ch++) begin
      prev  = (m_age(c, ch, 0) >= 1) ? m_last(c, ch, 1) : 1'b0;
      v[ch] = (mode_of(c) == 1) ? (m_last(c, ch, 0) & ~prev) : m_last(c, ch, 0);
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_dvalid(input int c);
    logic [NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = (m_age(c, ch, 0) >= dep_of(c) - 1);
    return v;
  endfunction

  function automatic logic [NCH-1:0] act_dout(input int c);
    case (c)
      0:       return dout_a;
      1:       return dout_b;
      default: return dout_c;
    endcase
  endfunction

  function automatic logic [NCH-1:0] act_dvalid(input int c);
    case (c)
      0:       return dvalid_a;
      1:       return dvalid_b;
      default: return dvalid_c;
    endcase
  endfunction

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [NCH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("%s_dout_cfg%0d", tag, c), act_dout(c), m_dout(c));
      chk($sformatf("%s_dvalid_cfg%0d", tag, c), act_dvalid(c), m_dvalid(c));
    end
  endtask

  // Driver
  task automatic drive(input logic r1, input logic [NCH-1:0] rc, input logic [NCH-1:0] st);
    rst1   = r1;
    rst_ch = rc;
    start  = st;
    model_async();
  endtask

  typedef struct {
    logic           r1;
    logic [NCH-1:0] rc;
    logic [NCH-1:0] st;
    logic [NCH-1:0] e_dout;
    logic [NCH-1:0] e_dv;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_a;
    int n_c;
    int disturbed;
    int r;
    logic [NCH-1:0] rc;
    logic [NCH-1:0] st;
    logic [NCH-1:0] e;

    for (int ch = 0; ch < NCH; ch++) begin
      for (int i = 0; i < HL; i++) begin
        hist_sc[ch][i] = 0;
        hist_s0[ch][i] = 1'b0;
      end
    end

    // Expected values for the DEPTH=3 / SYNC_STAGES=2 level instance.
    tbl[0]  = '{1'b1, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h0, 4'hF, 4'hF, 4'hF};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'hF, 4'hF};
    tbl[6]  = '{1'b0, 4'h0, 4'hF, 4'hF, 4'hF};
    tbl[7]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF};
    tbl[8]  = '{1'b0, 4'h0, 4'h5, 4'hF, 4'hF};
    tbl[9]  = '{1'b0, 4'h0, 4'h5, 4'hF, 4'hF};
    tbl[10] = '{1'b0, 4'h0, 4'h5, 4'h5, 4'hF};
    tbl[11] = '{1'b0, 4'h2, 4'hF, 4'h5, 4'hD};
    tbl[12] = '{1'b0, 4'h0, 4'hF, 4'h5, 4'hD};
    tbl[13] = '{1'b0, 4'h0, 4'hF, 4'hD, 4'hD};
    tbl[14] = '{1'b0, 4'h0, 4'hF, 4'hD, 4'hD};
    tbl[15] = '{1'b0, 4'h0, 4'hF, 4'hF, 4'hF};

    @(negedge clock0);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r1, tbl[i].rc, tbl[i].st);
      @(negedge clock0);
      chk($sformatf("tbl%0d_dout", i), dout_a, tbl[i].e_dout);
      chk($sformatf("tbl%0d_dvalid", i), dvalid_a, tbl[i].e_dv);
      check_all($sformatf("tbl%0d", i));
    end

    // rst1 pulse mid-stream clears at once; count edges until fill completes.
    drive(1'b1, 4'h0, 4'hF);
    #1;
    chk("rst1_dout_a", dout_a, 4'h0);
    chk("rst1_dvalid_a", dvalid_a, 4'h0);
    chk("rst1_dout_c", dout_c, 4'h0);
    chk("rst1_dvalid_c", dvalid_c, 4'h0);
    @(negedge clock0);
    @(negedge clock0);
    drive(1'b0, 4'h0, 4'hF);
    n_a = -1;
    n_c = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock0);
      #1;
      if (n_a < 0 && dvalid_a == 4'hF) n_a = i;
      if (n_c < 0 && dvalid_c == 4'hF) n_c = i;
    end
    @(negedge clock0);
    chk_int("rst1_release_dvalid_a_edges", n_a, 4);
    chk_int("rst1_release_dvalid_c_edges", n_c, 3);
    check_all("after_rst1");

    // Latency: level DEPTH=3 shows start after 3 edges, DEPTH=1 after 1.
    drive(1'b0, 4'h0, 4'h0);
    repeat (4) @(negedge clock0);
    drive(1'b0, 4'h0, 4'h1);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clock0);
      chk($sformatf("lat_a0_e%0d", j), {3'b000, dout_a[0]}, (j >= 3) ? 4'h1 : 4'h0);
      chk($sformatf("lat_c0_e%0d", j), {3'b000, dout_c[0]}, 4'h1);
      check_all("lat");
    end

    // Rise mode on channel 1: one pulse two edges after the rise, none on the fall.
    drive(1'b0, 4'h0, 4'h0);
    repeat (4) @(negedge clock0);
    for (int j = 1; j <= 10; j++) exp_q.push_back((j == 2) ? 4'h1 : 4'h0);
    drive(1'b0, 4'h0, 4'h2);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock0);
      e = exp_q.pop_front();
      chk($sformatf("rise_b1_e%0d", j), {3'b000, dout_b[1]}, e);
      check_all("rise");
      if (j == 5) drive(1'b0, 4'h0, 4'h0);
    end

    // Sub-cycle rst_ch[2] pulse with everything high.
    drive(1'b0, 4'h0, 4'hF);
    repeat (5) @(negedge clock0);
    drive(1'b0, 4'h4, 4'hF);
    #3;
    drive(1'b0, 4'h0, 4'hF);
    #1;
    chk("iso_dout_a", dout_a, 4'b1011);
    chk("iso_dvalid_a", dvalid_a, 4'b1011);
    check_all("iso_pulse");
    n_a = -1;
    disturbed = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock0);
      #1;
      if (n_a < 0 && dout_a[2]) n_a = i;
      if ((dout_a & 4'b1011) != 4'b1011 || (dvalid_a & 4'b1011) != 4'b1011) disturbed++;
    end
    @(negedge clock0);
    chk_int("iso_dout_a2_return_edges", n_a, 4);
    chk_int("iso_other_channels_disturbed", disturbed, 0);
    check_all("iso_done");

    // rst_ch[0] held: stage 0 still holds start, so dout returns as soon as
    // the chain refills after the local reset releases.
    drive(1'b0, 4'h1, 4'hF);
    repeat (4) @(negedge clock0);
    chk("hold_dvalid_a", dvalid_a, 4'b1110);
    drive(1'b0, 4'h0, 4'hF);
    n_a = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock0);
      #1;
      if (n_a < 0 && dout_a[0]) n_a = i;
    end
    @(negedge clock0);
    chk_int("hold_dout_a0_return_edges", n_a, 4);

    // Random stimulus against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      check_all("rand");
      r  = $urandom_range(0, 99);
      st = NCH'($urandom);
      for (int b = 0; b < NCH; b++) rc[b] = ($urandom_range(0, 15) == 0);
      if (r >= 2 && r < 10) begin
        drive(1'b0, NCH'(1 << $urandom_range(0, NCH - 1)), st);
        #2;
        check_all("rand_pulse");
        drive(1'b0, 4'h0, st);
      end else begin
        drive(r < 2, rc, st);
      end
      @(negedge clock0);
    end
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
